// File: rtl/fifo_buffer.sv
// -----------------------------------------------------------------------------
// fifo_buffer
//   Synchronous first-word-fall-through FIFO with valid/ready handshake on both
//   sides. Decouples a producer from a consumer in one clock domain and absorbs
//   bursts of up to DEPTH words.
//
// Parameters
//   WIDTH : data word width in bits (>= 1)
//   DEPTH : number of entries, power of two (>= 2)
//   AW    : pointer index width, derived from DEPTH (do not override)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   write data
//   in_valid   in   producer offers in_data
//   in_ready   out  buffer can accept a word (not full), from pointers only
//   out_data   out  head-of-queue word, meaningful while out_valid=1
//   out_valid  out  buffer holds at least one word (not empty), from pointers only
//   out_ready  in   consumer takes out_data
//   level      out  occupancy 0..DEPTH (only with FIFO_BUFFER_LEVEL_EN)
//
// Configuration
//   FIFO_BUFFER_LEVEL_EN : define to add the level occupancy output.
// -----------------------------------------------------------------------------
module fifo_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FIFO_BUFFER_LEVEL_EN
    ,
    output logic [AW:0]      level
`endif
);

    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Status flags depend only on the pointer registers.
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
    end

    // Transfers are gated by ready/valid, so overflow/underflow cannot occur.
    always_comb begin
        w_push = in_valid && !w_full;
        w_pop  = out_ready && !w_empty;
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    // FWFT: the head word is presented directly from storage.
    assign out_data = r_mem[r_rd_ptr[AW-1:0]];

    // Write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

`ifdef FIFO_BUFFER_LEVEL_EN
    // Occupancy counter tracking wr_ptr - rd_ptr on the same edges.
    logic [PW-1:0] r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_push && !w_pop) begin
            r_level <= r_level + PW'(1);
        end else if (w_pop && !w_push) begin
            r_level <= r_level - PW'(1);
        end
    end

    assign level = r_level;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_buffer
//   Directed self-checking bench for fifo_buffer (WIDTH=8, DEPTH=4).
// -----------------------------------------------------------------------------
module tb_fifo_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef FIFO_BUFFER_LEVEL_EN
    logic [2:0] level;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_buffer #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef FIFO_BUFFER_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef FIFO_BUFFER_LEVEL_EN
        check(tag, 32'(level), 32'(exp));
`else
        check(tag, 32'(in_ready), 32'(exp != 4));
`endif
    endtask

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_word;
        int push_idx;
        int cycles;

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset then idle
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_level("rst_level", 0);
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Fill to full: A1..A4
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA1 + i);
            tick();
            check("fill_out_valid", 32'(out_valid), 32'd1);
            check("fill_head", 32'(out_data), 32'hA1);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check_level("full_level", 4);

        // Fifth word held for 3 cycles must be refused
        in_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_in_ready", 32'(in_ready), 32'd0);
            check("held_head", 32'(out_data), 32'hA1);
        end
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'(8'hA1 + i));
            tick();
        end
        out_ready = 1'b0;
        check("drained_out_valid", 32'(out_valid), 32'd0);
        check("drained_in_ready", 32'(in_ready), 32'd1);
        check_level("drained_level", 0);

        // Simultaneous push/pop at level 2
        in_valid = 1'b1;
        in_data  = 8'h20;
        tick();
        in_data  = 8'h21;
        tick();
        check_level("lvl2_level", 2);
        check("lvl2_head", 32'(out_data), 32'h20);
        in_data   = 8'h10;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_level("pushpop_level", 2);
        check("pushpop_head", 32'(out_data), 32'h21);

        // Fill to full again: queue = 21,10,30,31
        in_data = 8'h30;
        tick();
        in_data = 8'h31;
        tick();
        check("refill_in_ready", 32'(in_ready), 32'd0);

        // Full boundary: push and pop together -> only the pop happens
        in_data   = 8'h40;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fullpp_in_ready", 32'(in_ready), 32'd1);
        check_level("fullpp_level", 3);
        check("fullpp_head", 32'(out_data), 32'h10);

        // Drain the rest; 0x40 must not have been stored
        out_ready = 1'b1;
        check("fb_drain0", 32'(out_data), 32'h10);
        tick();
        check("fb_drain1", 32'(out_data), 32'h30);
        tick();
        check("fb_drain2", 32'(out_data), 32'h31);
        tick();
        out_ready = 1'b0;
        check("fb_empty", 32'(out_valid), 32'd0);

        // Wrap-around: 0x00..0x09 with random out_ready
        exp_word = 0;
        push_idx = 0;
        cycles   = 0;
        while (exp_word < 10 && cycles < 200) begin
            in_valid  = (push_idx < 10);
            in_data   = 8'(push_idx);
            out_ready = (push_idx >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                check("wrap_data", 32'(out_data), 32'(exp_word));
                exp_word++;
            end
            if (in_valid && in_ready) push_idx++;
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrap_count", 32'(exp_word), 32'd10);
        check("wrap_empty", 32'(out_valid), 32'd0);

        // Async reset pulse between edges at level 3
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h50 + i);
            tick();
        end
        in_valid = 1'b0;
        check_level("pre_rst_level", 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check_level("async_level", 0);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_head", 32'(out_data), 32'h77);
        check_level("post_rst_level", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
